// File: rtl/hilo_mult_unit.sv
// Multicycle control and HI/LO result stage wrapped around an external
// 32x32 signed combinational multiplier. Handles MULT/MULTU/MTHI/MTLO and
// raises stall for MFHI/MFLO while a multiply is in flight.
module hilo_mult_unit #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_req,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_z,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int unsigned CW = 4;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_MTHI  = 2'b10;
    localparam logic [1:0] OP_MTLO  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            uns, uns_nxt;
    logic [31:0]     mul_x_nxt, mul_y_nxt;
    logic [31:0]     hi_nxt, lo_nxt;
    logic            busy_nxt, done_nxt;
    logic [63:0]     prod_fix;

    // Signed product turned into the unsigned one when the op was MULTU
    always_comb begin
        prod_fix = mul_z;
        if (uns) begin
            prod_fix = mul_z
                     + (mul_x[31] ? {mul_y, 32'b0} : 64'b0)
                     + (mul_y[31] ? {mul_x, 32'b0} : 64'b0);
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        uns_nxt   = uns;
        mul_x_nxt = mul_x;
        mul_y_nxt = mul_y;
        hi_nxt    = hi;
        lo_nxt    = lo;
        busy_nxt  = busy;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            mul_x_nxt = rs_val;
                            mul_y_nxt = rt_val;
                            uns_nxt   = (op == OP_MULTU);
                            cnt_nxt   = CW'(MUL_CYCLES);
                            busy_nxt  = 1'b1;
                            state_nxt = RUN;
                        end
                        OP_MTHI: hi_nxt = rs_val;
                        OP_MTLO: lo_nxt = rs_val;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    {hi_nxt, lo_nxt} = prod_fix;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            uns   <= 1'b0;
            mul_x <= '0;
            mul_y <= '0;
            hi    <= '0;
            lo    <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            uns   <= uns_nxt;
            mul_x <= mul_x_nxt;
            mul_y <= mul_y_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    // MFHI/MFLO must wait while a product is pending
    assign stall = mf_req & busy;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit with a behavioural multiplier and
// a HI/LO reference model built from plain 64-bit arithmetic.
module tb_hilo_mult_unit;

    localparam int unsigned MC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        mf_req;
    logic [31:0] mul_x, mul_y;
    logic [63:0] mul_z;
    logic [31:0] hi, lo;
    logic        busy, done, stall;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_hi, m_lo;

    hilo_mult_unit #(.MUL_CYCLES(MC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .mf_req (mf_req),
        .mul_x  (mul_x),
        .mul_y  (mul_y),
        .mul_z  (mul_z),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy),
        .done   (done),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    // Stand-in for the signed combinational Booth multiplier
    logic signed [63:0] sx, sy;
    assign sx    = {{32{mul_x[31]}}, mul_x};
    assign sy    = {{32{mul_y[31]}}, mul_y};
    assign mul_z = sx * sy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref_prod(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        if (o == 2'b01)
            return {32'b0, a} * {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
    endfunction

    // Issue one multiply; optionally keep an MTLO request on start while busy
    task automatic do_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold_mtlo);
        logic [63:0] exp;
        int cyc;
        exp = ref_prod(o, a, b);
        cyc = 0;
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        step();
        if (hold_mtlo) begin
            op = 2'b11; rs_val = 32'h0000_1234;
        end else begin
            start = 1'b0;
        end
        while (busy === 1'b1 && cyc < 40) begin
            cyc++;
            mf_req = 1'($urandom_range(0, 1));
            #1;
            chk("stall_busy", 64'(stall), 64'(mf_req));
            chk("done_low_busy", 64'(done), 64'(0));
            chk("operands_held", {mul_x, mul_y}, {a, b});
            @(posedge clk);
            #1;
        end
        mf_req = 1'b0;
        chk("busy_cycles", 64'(cyc), 64'(MC));
        chk("done_pulse", 64'(done), 64'(1));
        chk("hilo_result", {hi, lo}, exp);
        mf_req = 1'b1;
        #1;
        chk("stall_idle", 64'(stall), 64'(0));
        mf_req = 1'b0;
        start = 1'b0;
        step();
        chk("done_single", 64'(done), 64'(0));
        chk("hilo_hold", {hi, lo}, exp);
        {m_hi, m_lo} = exp;
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  ro;

        reset = 1'b1; start = 1'b1; op = 2'b00; rs_val = 32'd3; rt_val = 32'd3; mf_req = 1'b0;
        step();
        step();
        reset = 1'b0; start = 1'b0;
        chk("rst_hilo", {hi, lo}, 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_xy", {mul_x, mul_y}, 64'(0));
        m_hi = '0; m_lo = '0;

        do_mul(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0);
        chk("mult_neg3x5", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        do_mul(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        do_mul(2'b01, 32'h8000_0000, 32'd2, 1'b0);
        chk("multu_msb", {hi, lo}, 64'h0000_0001_0000_0000);
        do_mul(2'b00, 32'h1234_5678, 32'h8765_4321, 1'b1);

        // MTHI then MTLO back to back
        start = 1'b1; op = 2'b10; rs_val = 32'hDEAD_BEEF;
        step();
        chk("mthi", 64'(hi), 64'(32'hDEAD_BEEF));
        chk("mthi_busy_done", {62'b0, busy, done}, 64'(0));
        op = 2'b11; rs_val = 32'h0BAD_F00D;
        step();
        start = 1'b0;
        chk("mtlo", {hi, lo}, 64'hDEAD_BEEF_0BAD_F00D);
        chk("mtlo_busy_done", {62'b0, busy, done}, 64'(0));
        m_hi = 32'hDEAD_BEEF; m_lo = 32'h0BAD_F00D;

        // Reset one cycle into a multiply abandons it
        start = 1'b1; op = 2'b00; rs_val = 32'd7; rt_val = 32'd6;
        step();
        start = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_hilo", {hi, lo}, 64'(0));
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_done", 64'(done), 64'(0));
            step();
        end
        do_mul(2'b00, 32'd7, 32'd6, 1'b0);
        chk("mult_7x6", {hi, lo}, 64'd42);

        // Random mix of all four operations
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom();
            rb = $urandom();
            if (i % 5 == 0) ra = 32'h8000_0000;
            if (i % 7 == 0) rb = 32'hFFFF_FFFF;
            if (ro[1] == 1'b0) begin
                do_mul(ro, ra, rb, 1'($urandom_range(0, 1)));
            end else begin
                start = 1'b1; op = ro; rs_val = ra;
                step();
                start = 1'b0;
                if (ro == 2'b10) m_hi = ra; else m_lo = ra;
                chk("rand_mt", {hi, lo}, {m_hi, m_lo});
                chk("rand_mt_busy_done", {62'b0, busy, done}, 64'(0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
